// File: rtl/ex_muldiv_ctrl.sv
// Sequencer for the shared HI/LO multiplier and divider: accepts one request from EX,
// stalls the pipeline, launches the selected unit and captures its 64-bit result.
`timescale 1ns/1ps
module ex_muldiv_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   input  logic        is_busbusy,
   output logic        stall_req,
   output logic        opreat_over,
   output logic [31:0] hi_value,
   output logic [31:0] lo_value,
   output logic        mul_start,
   output logic        mul_sign,
   output logic        div_start,
   output logic        div_sign,
   output logic        div_abort,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   input  logic [63:0] mul_result,
   input  logic [63:0] div_result,
   input  logic        div_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_e;

   localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        sign_q, sign_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, otherwise paths that
      // leave it untouched would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               op_a_d = req_a;
               op_b_d = req_b;
               sign_d = req_op[0];
               cnt_d  = 4'd0;
               if (!req_op[1]) begin
                  state_d = S_MUL;
               end else if (req_b != 32'd0) begin
                  state_d = S_DIV;
               end else begin
                  // Divide by zero completes immediately with a fixed result.
                  state_d = S_DONE;
                  hi_d    = req_a;
                  lo_d    = 32'hFFFF_FFFF;
               end
            end
         end

         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == MUL_LAST) begin
               hi_d    = mul_result[63:32];
               lo_d    = mul_result[31:0];
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               // A non-zero count marks that the start pulse has already gone out.
               cnt_d = 4'd1;
               if (div_done) begin
                  hi_d    = div_result[63:32];
                  lo_d    = div_result[31:0];
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            if (flush || !is_busbusy) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         sign_q  <= 1'b0;
         op_a_q  <= 32'd0;
         op_b_q  <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign stall_req   = ((state_q == S_IDLE) && req_valid && !flush) ||
                        (state_q == S_MUL) || (state_q == S_DIV);
   assign opreat_over = (state_q == S_DONE);
   assign mul_start   = (state_q == S_MUL) && (cnt_q == 4'd0);
   assign div_start   = (state_q == S_DIV) && (cnt_q == 4'd0);
   assign div_abort   = flush && (state_q == S_DIV);
   assign mul_sign    = sign_q;
   assign div_sign    = sign_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign hi_value    = hi_q;
   assign lo_value    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ex_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        flush, is_busbusy;
   logic        stall_req, opreat_over;
   logic [31:0] hi_value, lo_value;
   logic        mul_start, mul_sign, div_start, div_sign, div_abort;
   logic [31:0] op_a, op_b;
   logic [63:0] mul_result, div_result;
   logic        div_done;

   int checks = 0;
   int errors = 0;

   ex_muldiv_ctrl #(.MUL_LAT(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .flush(flush), .is_busbusy(is_busbusy),
      .stall_req(stall_req), .opreat_over(opreat_over),
      .hi_value(hi_value), .lo_value(lo_value),
      .mul_start(mul_start), .mul_sign(mul_sign),
      .div_start(div_start), .div_sign(div_sign), .div_abort(div_abort),
      .op_a(op_a), .op_b(op_b),
      .mul_result(mul_result), .div_result(div_result), .div_done(div_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear_req(); flush = 1'b0; is_busbusy = 1'b0;
      mul_result = 64'd0; div_result = 64'd0; div_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over, mul_start, mul_sign, div_start, div_sign, div_abort} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {stall_req, opreat_over, mul_start, mul_sign, div_start, div_sign, div_abort});
      end
      checks++;
      if ({hi_value, lo_value, op_a, op_b} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data: got hi=%h lo=%h a=%h b=%h expected all 0",
                  hi_value, lo_value, op_a, op_b);
      end
   endtask

   // mult -2 * 3 with MUL_LAT=2: accept T, start T+1, done T+3.
   task automatic run_mult_basic(input string tag);
      tick();
      req_valid = 1'b1; req_op = 2'b01; req_a = 32'hFFFF_FFFE; req_b = 32'd3;
      mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
      @(negedge clk);
      checks++;
      if ({stall_req, mul_start, opreat_over} !== 3'b100) begin
         errors++;
         $display("FAIL %s_T: got stall,start,over=%b expected 100", tag, {stall_req, mul_start, opreat_over});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall_req, mul_start, mul_sign, div_start, opreat_over} !== 5'b11100) begin
         errors++;
         $display("FAIL %s_T1: got stall,start,sign,dstart,over=%b expected 11100", tag,
                  {stall_req, mul_start, mul_sign, div_start, opreat_over});
      end
      checks++;
      if ({op_a, op_b} !== {32'hFFFF_FFFE, 32'd3}) begin
         errors++;
         $display("FAIL %s_ops: got a=%h b=%h expected fffffffe 00000003", tag, op_a, op_b);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall_req, mul_start, opreat_over} !== 3'b100) begin
         errors++;
         $display("FAIL %s_T2: got stall,start,over=%b expected 100", tag, {stall_req, mul_start, opreat_over});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over, hi_value, lo_value} !== {2'b01, 64'hFFFF_FFFF_FFFF_FFFA}) begin
         errors++;
         $display("FAIL %s_T3: got stall=%b over=%b hi=%h lo=%h expected 0 1 ffffffff fffffffa",
                  tag, stall_req, opreat_over, hi_value, lo_value);
      end
      tick();
      clear_req();
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over, hi_value, lo_value} !== {2'b00, 64'hFFFF_FFFF_FFFF_FFFA}) begin
         errors++;
         $display("FAIL %s_T4: got stall=%b over=%b hi=%h lo=%h expected 0 0 ffffffff fffffffa",
                  tag, stall_req, opreat_over, hi_value, lo_value);
      end
   endtask

   task automatic test_mult();
      run_mult_basic("mult");
   endtask

   task automatic test_divu_late();
      int bad = 0;
      tick();
      req_valid = 1'b1; req_op = 2'b10; req_a = 32'd100; req_b = 32'd7;
      @(negedge clk);
      checks++;
      if ({stall_req, div_start} !== 2'b10) begin
         errors++;
         $display("FAIL divu_T: got stall,dstart=%b expected 10", {stall_req, div_start});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall_req, div_start, div_sign, mul_start} !== 4'b1100) begin
         errors++;
         $display("FAIL divu_T1: got stall,dstart,dsign,mstart=%b expected 1100",
                  {stall_req, div_start, div_sign, mul_start});
      end
      for (int c = 2; c <= 32; c++) begin
         tick();
         @(negedge clk);
         if ({stall_req, div_start, opreat_over} !== 3'b100) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL divu_wait: got %0d bad cycles expected 0", bad);
      end
      tick();
      div_done = 1'b1; div_result = {32'd2, 32'd14};
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over} !== 2'b10) begin
         errors++;
         $display("FAIL divu_T33: got stall,over=%b expected 10", {stall_req, opreat_over});
      end
      tick();
      div_done = 1'b0; div_result = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over, hi_value, lo_value} !== {2'b01, 32'd2, 32'd14}) begin
         errors++;
         $display("FAIL divu_T34: got stall=%b over=%b hi=%h lo=%h expected 0 1 2 e",
                  stall_req, opreat_over, hi_value, lo_value);
      end
      tick();
      clear_req();
      @(negedge clk);
      checks++;
      if (opreat_over !== 1'b0) begin
         errors++;
         $display("FAIL divu_T35: got over=%b expected 0", opreat_over);
      end
   endtask

   task automatic test_div_by_zero();
      tick();
      req_valid = 1'b1; req_op = 2'b11; req_a = 32'd5; req_b = 32'd0;
      @(negedge clk);
      checks++;
      if (stall_req !== 1'b1) begin
         errors++;
         $display("FAIL dz_T: got stall=%b expected 1", stall_req);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over, div_start, div_sign, hi_value, lo_value} !==
          {4'b0101, 32'd5, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL dz_T1: got stall=%b over=%b dstart=%b dsign=%b hi=%h lo=%h expected 0 1 0 1 5 ffffffff",
                  stall_req, opreat_over, div_start, div_sign, hi_value, lo_value);
      end
      tick();
      clear_req();
      @(negedge clk);
      checks++;
      if ({opreat_over, div_start} !== 2'b00) begin
         errors++;
         $display("FAIL dz_T2: got over,dstart=%b expected 00", {opreat_over, div_start});
      end
   endtask

   task automatic test_held_result();
      int starts = 0;
      int bad = 0;
      tick();
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd4; mul_result = 64'd12;
      @(negedge clk); starts += int'(mul_start);
      tick(); @(negedge clk); starts += int'(mul_start);
      tick(); @(negedge clk); starts += int'(mul_start);
      for (int c = 3; c <= 7; c++) begin
         tick();
         is_busbusy = (c <= 6);
         mul_result = 64'hDEAD_BEEF_0BAD_F00D;
         @(negedge clk);
         starts += int'(mul_start);
         if ({stall_req, opreat_over, hi_value, lo_value} !== {2'b01, 32'd0, 32'd12}) bad++;
      end
      tick();
      is_busbusy = 1'b0;
      clear_req();
      @(negedge clk);
      starts += int'(mul_start);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL held_done: got %0d bad DONE cycles expected 0", bad);
      end
      checks++;
      if (opreat_over !== 1'b0) begin
         errors++;
         $display("FAIL held_exit: got over=%b expected 0", opreat_over);
      end
      checks++;
      if (starts !== 1) begin
         errors++;
         $display("FAIL held_starts: got %0d start pulses expected 1", starts);
      end
   endtask

   task automatic test_flush_div();
      int starts = 0;
      // A flushed accept must not launch anything.
      tick();
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd9; req_b = 32'd9; flush = 1'b1;
      @(negedge clk);
      checks++;
      if (stall_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_accept: got stall=%b expected 0", stall_req);
      end
      tick();
      flush = 1'b0; clear_req();
      @(negedge clk);
      checks++;
      if ({mul_start, stall_req, opreat_over} !== 3'b000) begin
         errors++;
         $display("FAIL flush_accept_next: got start,stall,over=%b expected 000",
                  {mul_start, stall_req, opreat_over});
      end
      tick();
      req_valid = 1'b1; req_op = 2'b11; req_a = 32'd100; req_b = 32'd7;
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         tick(); @(negedge clk); starts += int'(div_start);
      end
      checks++;
      if (starts !== 1) begin
         errors++;
         $display("FAIL flush_dstart: got %0d pulses expected 1", starts);
      end
      tick();
      flush = 1'b1; div_done = 1'b1; div_result = {32'h1111_1111, 32'h2222_2222};
      @(negedge clk);
      checks++;
      if ({div_abort, stall_req} !== 2'b11) begin
         errors++;
         $display("FAIL flush_T5: got abort,stall=%b expected 11", {div_abort, stall_req});
      end
      tick();
      flush = 1'b0; div_done = 1'b0;
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd5; req_b = 32'd6; mul_result = 64'd30;
      @(negedge clk);
      checks++;
      if ({opreat_over, div_abort, stall_req, hi_value, lo_value} !== {3'b001, 32'd0, 32'd12}) begin
         errors++;
         $display("FAIL flush_T6: got over=%b abort=%b stall=%b hi=%h lo=%h expected 0 0 1 0 c",
                  opreat_over, div_abort, stall_req, hi_value, lo_value);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({mul_start, mul_sign} !== 2'b10) begin
         errors++;
         $display("FAIL flush_T7: got start,sign=%b expected 10", {mul_start, mul_sign});
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({opreat_over, hi_value, lo_value} !== {1'b1, 32'd0, 32'd30}) begin
         errors++;
         $display("FAIL flush_T9: got over=%b hi=%h lo=%h expected 1 0 1e", opreat_over, hi_value, lo_value);
      end
      tick();
      clear_req();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_mul();
      tick();
      req_valid = 1'b1; req_op = 2'b01; req_a = 32'd7; req_b = 32'd8;
      @(negedge clk);
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (mul_start !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_T1: got start=%b expected 1", mul_start);
      end
      tick();
      reset = 1'b0; clear_req();
      @(negedge clk);
      checks++;
      if ({stall_req, opreat_over, mul_start, mul_sign, div_start, div_sign, div_abort,
           hi_value, lo_value, op_a, op_b} !== 135'd0) begin
         errors++;
         $display("FAIL rst_mid_T2: got stall=%b over=%b ms=%b sg=%b hi=%h lo=%h a=%h b=%h expected all 0",
                  stall_req, opreat_over, mul_start, mul_sign, hi_value, lo_value, op_a, op_b);
      end
      run_mult_basic("rst_mult");
   endtask

   initial begin
      test_reset();
      test_mult();
      test_divu_late();
      test_div_by_zero();
      test_held_result();
      test_flush_div();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Sequencer for the shared multi-cycle HI/LO arithmetic resources (pipelined multiplier and iterative divider) used by the execute stage. It accepts one mult/multu/div/divu request from EX and holds EX with `stall_req` until the result is ready. It launches the multiplier or divider, waits for the result, and captures the 64-bit result into HI/LO result registers. It also handles divide-by-zero, downstream back-pressure (`is_busbusy`) and pipeline flush.

## Interface
Parameters:
- MUL_LAT, 2, multiplier latency in cycles, counted from the start cycle (legal 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EX holds a mult/multu/div/divu instruction
- req_op  in  2  00 multu, 01 mult, 10 divu, 11 div (bit0 = signed)
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- flush  in  1  exception/flush of EX; cancels the operation in flight
- is_busbusy  in  1  downstream stall; the completed result must be held
- stall_req  out  1  stall IF/ID/EX
- opreat_over  out  1  HI/LO result valid for the instruction in EX
- hi_value  out  32  captured HI result
- lo_value  out  32  captured LO result
- mul_start  out  1  one-cycle launch pulse to the multiplier
- mul_sign  out  1  signed multiply
- div_start  out  1  one-cycle launch pulse to the divider
- div_sign  out  1  signed divide
- div_abort  out  1  kill the divider iteration
- op_a  out  32  latched operand A to both units
- op_b  out  32  latched operand B to both units
- mul_result  in  64  {hi,lo} from the multiplier
- div_result  in  64  {remainder,quotient} from the divider
- div_done  in  1  divider result valid (single-cycle pulse)

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE:**
  - req_valid & ~flush: latch req_a/req_b into op_a/op_b, and latch the sign bit.
  - Next state: op 0x → MUL. op 1x with req_b≠0 → DIV. op 1x with req_b==0 → DONE, with hi_value←req_a and lo_value←32'hFFFF_FFFF (defined divide-by-zero result; no divider launch).
- **MUL:**
  - mul_start is high in the first MUL cycle only.
  - A 4-bit counter counts MUL cycles. In the MUL_LAT-th cycle, {hi_value,lo_value}←mul_result and the state moves to DONE.
- **DIV:**
  - div_start is high in the first DIV cycle only.
  - On div_done: hi_value←div_result[63:32] and lo_value←div_result[31:0]; next state DONE.
  - There is no timeout.
- **DONE:**
  - opreat_over=1 and stall_req=0.
  - Stays in DONE while is_busbusy=1, with the result held stable.
  - Goes to IDLE on the first cycle with is_busbusy=0.
  - req_valid is ignored in DONE, because it still refers to the completing instruction.
- **Flush:** flush=1 in MUL/DIV/DONE → IDLE next cycle.
  - div_abort = flush & (state==DIV).
  - hi_value/lo_value keep their pre-operation value. This means a capture scheduled in the same cycle as a flush is suppressed.
  - opreat_over is not asserted on the following cycle.
- **Output decode:**
  - stall_req = (IDLE & req_valid & ~flush) | MUL | DIV.
  - mul_sign/div_sign = latched sign bit; they are driven in every state.
- **Reset:** state IDLE, counter 0, op_a/op_b/hi_value/lo_value 0, sign 0. All outputs read 0 in the first cycle after reset. Reset overrides flush and req_valid.

## Timing
- Accept cycle T (IDLE & req_valid): stall_req=1 combinationally in T.
- Multiply: start pulse at T+1, capture at end of T+MUL_LAT, opreat_over at T+MUL_LAT+1. EX is stalled MUL_LAT+1 cycles (3 for MUL_LAT=2).
- Divide: start pulse at T+1. If div_done arrives at cycle D, opreat_over is asserted at D+1.
- Divide by zero: opreat_over at T+1; stall is 1 cycle.
- Back-to-back requests: the earliest next accept is the cycle after DONE exits. No request is lost, and each accepted request produces exactly one DONE.
- mul_start/div_start never assert outside the first cycle of MUL/DIV, and never on a flushed accept.

## Test plan
- **mult, MUL_LAT=2:** mult with req_a=32'hFFFF_FFFE (-2), req_b=3 → mul_sign=1, mul_start at T+1, bench mul_result=64'hFFFF_FFFF_FFFF_FFFA. Expect hi_value=FFFF_FFFF, lo_value=FFFF_FFFA, opreat_over at T+3, stall_req high T..T+2.
- **divu with late done:** divu 100/7, div_done at T+33 with div_result={32'd2,32'd14} → hi_value=2, lo_value=14, opreat_over at T+34, stall_req high T..T+33.
- **div by zero:** div with req_a=5, req_b=0 → no div_start, hi_value=5, lo_value=FFFF_FFFF, opreat_over at T+1.
- **Held result:** multu completes while is_busbusy=1 for 4 cycles → opreat_over and hi_value/lo_value stable for all 5 DONE cycles, then IDLE; exactly one start pulse.
- **Flush during DIV:** flush at T+5 → div_abort=1 at T+5, IDLE at T+6, hi_value/lo_value unchanged, no opreat_over. A new multu accepted at T+6 completes normally.
- **Reset mid-MUL:** reset at T+1 → all outputs 0 next cycle, state IDLE; a following request behaves as in the first scenario.
